// File: rtl/button_debounce_pulse_pkg.sv
// -----------------------------------------------------------------------------
// button_debounce_pulse_pkg
//
// Shared definitions for the push-button debounce block:
//   - state_e               : FSM state encoding, also presented on state_o
//   - DEFAULT_STABLE_CYCLES : stability window used for simulation builds
//   - is_level_high()       : debounced level implied by a given FSM state
// -----------------------------------------------------------------------------
package button_debounce_pulse_pkg;

    // The encoding is visible on state_o, so the values are fixed explicitly.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM_HI = 2'd1,
        HIGH   = 2'd2,
        ARM_LO = 2'd3
    } state_e;

    // Short window for simulation; hardware builds override with larger values.
    localparam int DEFAULT_STABLE_CYCLES = 4;

    // While arming a release (ARM_LO) the accepted level is still 1; while
    // arming a press (ARM_HI) it is still 0.
    function automatic logic is_level_high(input state_e st);
        return (st == HIGH) || (st == ARM_LO);
    endfunction

endpackage

// File: rtl/button_debounce_pulse_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//
// One-bit two-flop synchroniser for asynchronous inputs. A value of async_in
// first sampled at rising edge k appears on sync_out from edge k+1 onward.
//
// Ports:
//   clk      in   clock
//   reset    in   synchronous, active-high reset; clears both flops
//   async_in in   asynchronous input level
//   sync_out out  synchronised level (output of the second flop)
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/button_debounce_pulse.sv
// -----------------------------------------------------------------------------
// button_debounce_pulse
//
// Conditions a raw, bouncy push-button for the 4-bit lab counter: synchronises
// it to clk, requires STABLE_CYCLES consecutive cycles of a new level before
// accepting it, and emits one-cycle pulses on accepted press/release.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   synchronous, active-high reset
//   btn_in         in   raw button level (asynchronous, may bounce)
//   pulse_out      out  one-cycle pulse when a press is accepted
//   release_pulse  out  one-cycle pulse when a release is accepted
//   btn_level      out  debounced button level
//   state_o        out  current FSM state (IDLE=0, ARM_HI=1, HIGH=2, ARM_LO=3)
//
// A clean edge first sampled at edge k yields its pulse and level change at
// edge k+STABLE_CYCLES+2 (2 synchroniser edges + 1 arming edge + counting).
// -----------------------------------------------------------------------------
module button_debounce_pulse
    import button_debounce_pulse_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_in,
    output logic       pulse_out,
    output logic       release_pulse,
    output logic       btn_level,
    output logic [1:0] state_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync2;

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pulse_q;
    logic             pulse_d;
    logic             release_q;
    logic             release_d;
    logic             level_q;
    logic             level_d;
    logic             cnt_last;

    sync_2ff u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (btn_in),
        .sync_out (sync2)
    );

    assign cnt_last = (cnt_q == CNT_LAST);

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pulse_q   <= 1'b0;
            release_q <= 1'b0;
            level_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pulse_q   <= pulse_d;
            release_q <= release_d;
            level_q   <= level_d;
        end
    end

    // Next-state and stability counter. The counter only advances while the
    // new level persists and stops at CNT_LAST, where the state changes, so
    // it can never wrap. Any reversion discards progress.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (sync2) begin
                    state_d = ARM_HI;
                    cnt_d   = '0;
                end
            end
            ARM_HI: begin
                if (!sync2) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_last) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HIGH: begin
                if (!sync2) begin
                    state_d = ARM_LO;
                    cnt_d   = '0;
                end
            end
            ARM_LO: begin
                if (sync2) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else if (cnt_last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the transition being taken and registered, so
    // each pulse lands on the same edge as the state change it reports.
    always_comb begin
        pulse_d   = (state_q == ARM_HI) && sync2 && cnt_last;
        release_d = (state_q == ARM_LO) && !sync2 && cnt_last;
        level_d   = is_level_high(state_d);
    end

    assign pulse_out     = pulse_q;
    assign release_pulse = release_q;
    assign btn_level     = level_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_button_debounce_pulse.sv
// -----------------------------------------------------------------------------
// tb_button_debounce_pulse
//
// Directed bench for button_debounce_pulse with STABLE_CYCLES=4, 10 ns clock.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same
// point, i.e. they show the result of the edge just taken. After btn_in
// changes, the next rising edge is edge k, so the Nth step() leaves us just
// after edge k+N-1: a k+6 event is visible after step 7.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_button_debounce_pulse;

    logic       clk;
    logic       reset;
    logic       btn_in;
    logic       pulse_out;
    logic       release_pulse;
    logic       btn_level;
    logic [1:0] state_o;

    int checks;
    int errors;

    button_debounce_pulse #(
        .STABLE_CYCLES (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_in        (btn_in),
        .pulse_out     (pulse_out),
        .release_pulse (release_pulse),
        .btn_level     (btn_level),
        .state_o       (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        btn_in = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({pulse_out, release_pulse, btn_level, state_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_during: got p=%b r=%b l=%b s=%0d required all 0",
                     pulse_out, release_pulse, btn_level, state_o);
        end
        #6;
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if ({pulse_out, release_pulse, btn_level, state_o} !== 5'b0) begin
                errors++;
                $display("FAIL reset_after step %0d: got p=%b r=%b l=%b s=%0d required all 0",
                         i, pulse_out, release_pulse, btn_level, state_o);
            end
        end
    endtask

    // Starting in IDLE with a settled 0, hold btn_in=1 for 20 cycles.
    task automatic test_clean_press();
        logic [1:0] exp_s;
        btn_in = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            exp_s = (i <= 2) ? 2'd0 : (i <= 6) ? 2'd1 : 2'd2;
            checks++;
            if (pulse_out !== (i == 7)) begin
                errors++;
                $display("FAIL press_pulse step %0d: got %b required %b", i, pulse_out, (i == 7));
            end
            checks++;
            if (btn_level !== (i >= 7)) begin
                errors++;
                $display("FAIL press_level step %0d: got %b required %b", i, btn_level, (i >= 7));
            end
            checks++;
            if (release_pulse !== 1'b0) begin
                errors++;
                $display("FAIL press_release step %0d: got %b required 0", i, release_pulse);
            end
            checks++;
            if (state_o !== exp_s) begin
                errors++;
                $display("FAIL press_state step %0d: got %0d required %0d", i, state_o, exp_s);
            end
        end
    endtask

    // Starting in HIGH with a settled 1, hold btn_in=0 for 12 cycles.
    task automatic test_release();
        logic [1:0] exp_s;
        btn_in = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            exp_s = (i <= 2) ? 2'd2 : (i <= 6) ? 2'd3 : 2'd0;
            checks++;
            if (release_pulse !== (i == 7)) begin
                errors++;
                $display("FAIL rel_pulse step %0d: got %b required %b", i, release_pulse, (i == 7));
            end
            checks++;
            if (btn_level !== (i < 7)) begin
                errors++;
                $display("FAIL rel_level step %0d: got %b required %b", i, btn_level, (i < 7));
            end
            checks++;
            if (pulse_out !== 1'b0) begin
                errors++;
                $display("FAIL rel_press_pulse step %0d: got %b required 0", i, pulse_out);
            end
            checks++;
            if (state_o !== exp_s) begin
                errors++;
                $display("FAIL rel_state step %0d: got %0d required %0d", i, state_o, exp_s);
            end
        end
    endtask

    // 1,1,0 three times then a held 1: only the held 1 may be accepted.
    task automatic test_bouncy_press();
        logic [8:0] pattern;
        int         npulse;
        pattern = 9'b110_110_110;
        for (int i = 8; i >= 0; i--) begin
            btn_in = pattern[i];
            step();
            checks++;
            if (pulse_out !== 1'b0 || btn_level !== 1'b0 || state_o === 2'd2) begin
                errors++;
                $display("FAIL bounce_phase idx %0d: got p=%b l=%b s=%0d required p=0 l=0 s!=2",
                         8 - i, pulse_out, btn_level, state_o);
            end
        end
        btn_in = 1'b1;
        npulse = 0;
        for (int i = 1; i <= 15; i++) begin
            step();
            if (pulse_out === 1'b1) npulse++;
            checks++;
            if (pulse_out !== (i == 7)) begin
                errors++;
                $display("FAIL bounce_pulse step %0d: got %b required %b", i, pulse_out, (i == 7));
            end
        end
        checks++;
        if (npulse != 1) begin
            errors++;
            $display("FAIL bounce_count: got %0d pulses required 1", npulse);
        end
        checks++;
        if (btn_level !== 1'b1 || state_o !== 2'd2) begin
            errors++;
            $display("FAIL bounce_final: got l=%b s=%0d required l=1 s=2", btn_level, state_o);
        end
    endtask

    // From HIGH, drop btn_in for two cycles: ARM_LO is visited then abandoned.
    task automatic test_glitch_high();
        logic [1:0] exp_s;
        for (int i = 1; i <= 10; i++) begin
            btn_in = (i == 1 || i == 2) ? 1'b0 : 1'b1;
            step();
            exp_s = (i == 3 || i == 4) ? 2'd3 : 2'd2;
            checks++;
            if (state_o !== exp_s) begin
                errors++;
                $display("FAIL glitch_state step %0d: got %0d required %0d", i, state_o, exp_s);
            end
            checks++;
            if (release_pulse !== 1'b0 || pulse_out !== 1'b0 || btn_level !== 1'b1) begin
                errors++;
                $display("FAIL glitch_outs step %0d: got r=%b p=%b l=%b required r=0 p=0 l=1",
                         i, release_pulse, pulse_out, btn_level);
            end
        end
    endtask

    // Reset while arming a press, button still held: a fresh full-latency press follows.
    task automatic test_mid_reset();
        logic [1:0] exp_s;
        btn_in = 1'b1;
        step();
        step();
        step();
        checks++;
        if (state_o !== 2'd1) begin
            errors++;
            $display("FAIL midrst_arm: got state %0d required 1", state_o);
        end
        reset = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            step();
            checks++;
            if ({pulse_out, release_pulse, btn_level, state_o} !== 5'b0) begin
                errors++;
                $display("FAIL midrst_hold cycle %0d: got p=%b r=%b l=%b s=%0d required all 0",
                         i, pulse_out, release_pulse, btn_level, state_o);
            end
        end
        reset = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            exp_s = (i <= 2) ? 2'd0 : (i <= 6) ? 2'd1 : 2'd2;
            checks++;
            if (pulse_out !== (i == 7)) begin
                errors++;
                $display("FAIL midrst_pulse step %0d: got %b required %b", i, pulse_out, (i == 7));
            end
            checks++;
            if (state_o !== exp_s || btn_level !== (i >= 7)) begin
                errors++;
                $display("FAIL midrst_state step %0d: got s=%0d l=%b required s=%0d l=%b",
                         i, state_o, btn_level, exp_s, (i >= 7));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_clean_press();
        test_release();
        test_bouncy_press();
        test_glitch_high();
        test_release();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded 50000 ns time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/button_debounce_pulse.md
Name: button_debounce_pulse

Overview:
- Upstream conditioning stage for the lab's 4-bit synchronous counter.
- Takes a raw, asynchronous, bouncy push-button input and synchronises it to clk.
- Debounces it with a stability counter and FSM.
- Emits single-cycle press/release pulses; pulse_out drives the downstream counter's increment/enable, so one physical press gives one count.

Parameters:
- STABLE_CYCLES, 4, consecutive synchronised cycles of a new level required before it is accepted. Minimum 2; hardware builds use larger values.
- CNT_W, $clog2(STABLE_CYCLES), derived width of the stability counter. Not overridden by users.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_in  input  1  raw button level; asynchronous to clk, may bounce.
- pulse_out  output  1  one-cycle high pulse when a press is accepted.
- release_pulse  output  1  one-cycle high pulse when a release is accepted.
- btn_level  output  1  debounced button level.
- state_o  output  2  current FSM state, for debug/bench visibility.

Behaviour:
- Interface: reset is synchronous and active-high; clock is clk.
- Reset (sampled high at a rising edge):
  - Both synchroniser flops and the counter go to 0.
  - FSM goes to IDLE.
  - pulse_out, release_pulse and btn_level all go to 0.
  - Reset overrides all other activity, including mid-debounce.
- Synchroniser: two flops. sync2 reflects a btn_in value first sampled at edge k from edge k+1 onward.
- FSM inputs and outputs: the FSM reads sync2 only. All outputs are registered.
- IDLE (level 0):
  - sync2=1 -> ARM_HI, cnt=0.
  - Otherwise stay.
- ARM_HI:
  - sync2=0 -> IDLE, no pulse.
  - sync2=1 and cnt==STABLE_CYCLES-1 -> HIGH; pulse_out=1 for that one cycle; btn_level=1.
  - Otherwise cnt+1.
- HIGH (level 1):
  - sync2=0 -> ARM_LO, cnt=0.
  - Otherwise stay.
- ARM_LO:
  - sync2=1 -> HIGH, no pulse.
  - sync2=0 and cnt==STABLE_CYCLES-1 -> IDLE; release_pulse=1 for that one cycle; btn_level=0.
  - Otherwise cnt+1.
- Latency: a clean transition first sampled at edge k produces its pulse and level change at edge k+STABLE_CYCLES+2. With the default of 4 that is edge k+6.
- Pulse width: pulses are exactly one cycle wide. They are never asserted in consecutive cycles, and never both asserted together.
- Bounce/glitch: any reversion during ARM_* returns to the previous stable state and discards progress. The next attempt restarts cnt at 0.
- Counter: never exceeds STABLE_CYCLES-1, so no wrap-around.
- Button held through reset: treated as a new press after reset deasserts. A full-latency pulse_out follows.
- State encoding: IDLE=0, ARM_HI=1, HIGH=2, ARM_LO=3, presented on state_o.

Decomposition:
- Shared package:
  - State encoding localparams (IDLE, ARM_HI, HIGH, ARM_LO).
  - Default STABLE_CYCLES constant for simulation.
- Sub-module sync_2ff: 1-bit two-flop synchroniser with synchronous reset. It is reusable for other asynchronous lab inputs.

Test Plan (STABLE_CYCLES=4, 10 ns clock):
- Reset: reset=1 for 12 ns, btn_in=0 -> pulse_out=0, release_pulse=0, btn_level=0, state_o=0 throughout.
- Clean press: btn_in=1 set before edge k, held 20 cycles -> pulse_out high for exactly the cycle after edge k+6; btn_level=1 from edge k+6; state_o=2.
- Bouncy press: pattern 1,1,0 repeated 3 times, then 1 held -> exactly one pulse_out, at 6 edges after the first sample of the final held 1.
- Release: from HIGH, btn_in=0 held -> release_pulse for one cycle at edge k+6; btn_level=0; pulse_out stays 0.
- Glitch while HIGH: btn_in=0 for 2 cycles -> state_o visits 3 then returns to 2; no release_pulse; btn_level stays 1.
- Mid-operation reset: assert reset while state_o=1 with button held -> outputs 0 and state_o=0; after deassertion with button still held, pulse_out at edge k+6 (k = first non-reset edge).
